// File: rtl/lamp_seq_monitor_pkg.sv
// Shared lamp codes, monitor state encodings and fault codes for the lamp stage
// and its downstream sequence monitor.
package lamp_seq_monitor_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;

    // Low two bits of the lamp states double as the externally visible phase number.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_RED    = 3'd3,
        ST_FAULT  = 3'd4
    } mon_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_ENCODING = 2'd1,
        FAULT_ORDER    = 2'd2,
        FAULT_TIMEOUT  = 2'd3
    } fault_code_t;

    function automatic logic lamp_legal(input logic [2:0] l);
        return (l == LAMP_RED) || (l == LAMP_GREEN) || (l == LAMP_YELLOW);
    endfunction

    function automatic mon_state_t lamp_state(input logic [2:0] l);
        case (l)
            LAMP_GREEN:  return ST_GREEN;
            LAMP_YELLOW: return ST_YELLOW;
            LAMP_RED:    return ST_RED;
            default:     return ST_IDLE;
        endcase
    endfunction

    function automatic mon_state_t next_phase(input mon_state_t s);
        case (s)
            ST_GREEN:  return ST_YELLOW;
            ST_YELLOW: return ST_RED;
            ST_RED:    return ST_GREEN;
            default:   return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/lamp_seq_monitor_if.sv
// Lamp bus plus monitor status outputs; the lamp side drives light, the monitor
// drives everything else.
interface lamp_seq_monitor_if #(
    parameter int CNT_W = 16,
    parameter int DW_W  = 8
);
    import lamp_seq_monitor_pkg::*;

    logic [2:0]       light;
    logic [1:0]       phase;
    logic             phase_done;
    logic [DW_W-1:0]  dwell_last;
    logic [CNT_W-1:0] cycle_count;
    logic             fault;
    fault_code_t      fault_code;

    modport master (
        output light,
        input  phase, phase_done, dwell_last, cycle_count, fault, fault_code
    );

    modport slave (
        input  light,
        output phase, phase_done, dwell_last, cycle_count, fault, fault_code
    );

endinterface

// File: rtl/lamp_seq_monitor_sat_counter.sv
// Saturating up-counter: clr forces 0, load forces 1, inc counts up and holds at all-ones.
module lamp_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    input  logic             load,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= WIDTH'(1);
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lamp_seq_monitor.sv
// Checks the one-hot lamp bus for the GREEN->YELLOW->RED order, measures per-phase
// dwell, counts completed cycles and latches the first fault until reset.
module lamp_seq_monitor
    import lamp_seq_monitor_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DW_W      = 8,
    parameter int MAX_DWELL = 200
) (
    input  logic clk,
    input  logic rst,
    lamp_seq_monitor_if.slave bus
);

    mon_state_t       state, state_n;
    fault_code_t      fault_code, fault_code_n;
    logic             phase_done, phase_done_n;
    logic [DW_W-1:0]  dwell_last, dwell_last_n;
    logic [DW_W-1:0]  dwell_cnt;
    logic [CNT_W-1:0] cycle_count;
    logic             dwell_inc, dwell_load, cycle_inc;
    mon_state_t       seen;

    assign seen = lamp_state(bus.light);

    lamp_sat_counter #(.WIDTH(DW_W)) u_dwell (
        .clk   (clk),
        .inc   (dwell_inc),
        .clr   (rst),
        .load  (dwell_load),
        .count (dwell_cnt)
    );

    lamp_sat_counter #(.WIDTH(CNT_W)) u_cycles (
        .clk   (clk),
        .inc   (cycle_inc),
        .clr   (rst),
        .load  (1'b0),
        .count (cycle_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            fault_code <= FAULT_NONE;
            phase_done <= 1'b0;
            dwell_last <= '0;
        end else begin
            state      <= state_n;
            fault_code <= fault_code_n;
            phase_done <= phase_done_n;
            dwell_last <= dwell_last_n;
        end
    end

    // Holding the same code one more cycle reaches MAX_DWELL when the count sits one below it.
    always_comb begin
        state_n      = state;
        fault_code_n = fault_code;
        phase_done_n = 1'b0;
        dwell_last_n = dwell_last;
        dwell_inc    = 1'b0;
        dwell_load   = 1'b0;
        cycle_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (lamp_legal(bus.light)) begin
                    state_n    = seen;
                    dwell_load = 1'b1;
                end
            end
            ST_GREEN, ST_YELLOW, ST_RED: begin
                if (!lamp_legal(bus.light)) begin
                    state_n      = ST_FAULT;
                    fault_code_n = FAULT_ENCODING;
                end else if (seen == state) begin
                    dwell_inc = 1'b1;
                    if (dwell_cnt == DW_W'(MAX_DWELL - 1)) begin
                        state_n      = ST_FAULT;
                        fault_code_n = FAULT_TIMEOUT;
                    end
                end else if (seen == next_phase(state)) begin
                    state_n      = seen;
                    phase_done_n = 1'b1;
                    dwell_last_n = dwell_cnt;
                    dwell_load   = 1'b1;
                    cycle_inc    = (state == ST_RED);
                end else begin
                    state_n      = ST_FAULT;
                    fault_code_n = FAULT_ORDER;
                end
            end
            default: begin
                state_n = ST_FAULT;
            end
        endcase
    end

    assign bus.phase       = (state == ST_FAULT) ? 2'd0 : state[1:0];
    assign bus.phase_done  = phase_done;
    assign bus.dwell_last  = dwell_last;
    assign bus.cycle_count = cycle_count;
    assign bus.fault       = (state == ST_FAULT);
    assign bus.fault_code  = fault_code;

endmodule

// File: tb/tb_lamp_seq_monitor.sv
// Directed bench for lamp_seq_monitor: a phase-index model of the lamp order is
// compared against the DUT every cycle, plus hand-computed spot checks.
module tb_lamp_seq_monitor;
    import lamp_seq_monitor_pkg::*;

    localparam int CNT_W     = 2;
    localparam int DW_W      = 4;
    localparam int MAX_DWELL = 4;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    localparam logic [2:0] G   = 3'b010;
    localparam logic [2:0] Y   = 3'b001;
    localparam logic [2:0] R   = 3'b100;
    localparam logic [2:0] OFF = 3'b000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    lamp_seq_monitor_if #(.CNT_W(CNT_W), .DW_W(DW_W)) bus ();

    lamp_seq_monitor #(.CNT_W(CNT_W), .DW_W(DW_W), .MAX_DWELL(MAX_DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: phase index 1=G 2=Y 3=R, successor is (p mod 3)+1; run is the current dwell.
    bit m_valid = 0;
    int m_phase, m_done, m_dwell_last, m_cycles, m_fault, m_code, m_run;

    function automatic int lampIndex(input logic [2:0] l);
        if ($countones(l) != 1) return 0;
        if (l == G) return 1;
        if (l == Y) return 2;
        return 3;
    endfunction

    task automatic modelStep(input logic r, input logic [2:0] l);
        int idx;
        idx = lampIndex(l);
        m_valid = 1;
        if (r) begin
            m_phase = 0; m_done = 0; m_dwell_last = 0;
            m_cycles = 0; m_fault = 0; m_code = 0; m_run = 0;
        end else if (m_fault == 0) begin
            m_done = 0;
            if (m_phase == 0) begin
                if (idx != 0) begin
                    m_phase = idx;
                    m_run = 1;
                end
            end else if (idx == 0) begin
                m_fault = 1; m_code = 1;
            end else if (idx == m_phase) begin
                m_run++;
                if (m_run == MAX_DWELL) begin
                    m_fault = 1; m_code = 3;
                end
            end else if (idx == (m_phase % 3) + 1) begin
                m_done = 1;
                m_dwell_last = m_run;
                m_run = 1;
                if (m_phase == 3 && m_cycles < CNT_MAX) m_cycles++;
                m_phase = idx;
            end else begin
                m_fault = 1; m_code = 2;
            end
        end else begin
            m_done = 0;
        end
    endtask

    task automatic checkOutput(input string name, input int unsigned actual,
                               input int unsigned expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [2:0] l);
        rst = r;
        bus.light = l;
        @(posedge clk);
        modelStep(r, l);
        #2;
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("model.phase", int'(bus.phase), (m_fault != 0) ? 0 : m_phase);
            checkOutput("model.phase_done", int'(bus.phase_done), m_done);
            checkOutput("model.dwell_last", int'(bus.dwell_last), m_dwell_last);
            checkOutput("model.cycle_count", int'(bus.cycle_count), m_cycles);
            checkOutput("model.fault", int'(bus.fault), m_fault);
            checkOutput("model.fault_code", int'(bus.fault_code), m_code);
        end
    end

    initial begin
        bus.light = OFF;

        // Reset state
        applyStimulus(1, OFF);
        applyStimulus(1, OFF);
        checkOutput("rst.phase", int'(bus.phase), 0);
        checkOutput("rst.done", int'(bus.phase_done), 0);
        checkOutput("rst.fault", int'(bus.fault), 0);
        checkOutput("rst.code", int'(bus.fault_code), 0);
        checkOutput("rst.cycles", int'(bus.cycle_count), 0);
        checkOutput("rst.dwell_last", int'(bus.dwell_last), 0);

        // Normal run, one clock per phase
        applyStimulus(0, G);
        checkOutput("run.first_phase", int'(bus.phase), 1);
        checkOutput("run.first_done", int'(bus.phase_done), 0);
        applyStimulus(0, Y);
        checkOutput("run.y_done", int'(bus.phase_done), 1);
        checkOutput("run.y_dwell", int'(bus.dwell_last), 1);
        checkOutput("run.y_phase", int'(bus.phase), 2);
        applyStimulus(0, R);
        checkOutput("run.r_phase", int'(bus.phase), 3);
        applyStimulus(0, G);
        checkOutput("run.cycles1", int'(bus.cycle_count), 1);
        applyStimulus(0, Y);
        applyStimulus(0, R);
        applyStimulus(0, G);
        checkOutput("run.cycles2", int'(bus.cycle_count), 2);
        checkOutput("run.done_last", int'(bus.phase_done), 1);
        checkOutput("run.dwell_last", int'(bus.dwell_last), 1);
        checkOutput("run.fault", int'(bus.fault), 0);

        // Dwell of three cycles
        applyStimulus(1, OFF);
        applyStimulus(0, G);
        applyStimulus(0, G);
        checkOutput("dwell.no_pulse", int'(bus.phase_done), 0);
        applyStimulus(0, G);
        applyStimulus(0, Y);
        checkOutput("dwell.pulse", int'(bus.phase_done), 1);
        checkOutput("dwell.last", int'(bus.dwell_last), 3);
        checkOutput("dwell.phase", int'(bus.phase), 2);
        applyStimulus(0, Y);
        checkOutput("dwell.single_pulse", int'(bus.phase_done), 0);

        // Order error is sticky
        applyStimulus(1, OFF);
        applyStimulus(0, G);
        applyStimulus(0, R);
        checkOutput("order.fault", int'(bus.fault), 1);
        checkOutput("order.code", int'(bus.fault_code), 2);
        checkOutput("order.phase", int'(bus.phase), 0);
        applyStimulus(0, G);
        applyStimulus(0, Y);
        applyStimulus(0, R);
        applyStimulus(0, G);
        checkOutput("order.code_held", int'(bus.fault_code), 2);
        checkOutput("order.cycles_frozen", int'(bus.cycle_count), 0);
        checkOutput("order.no_done", int'(bus.phase_done), 0);

        // Encoding error, first code wins
        applyStimulus(1, OFF);
        applyStimulus(0, G);
        applyStimulus(0, 3'b110);
        checkOutput("enc.fault", int'(bus.fault), 1);
        checkOutput("enc.code", int'(bus.fault_code), 1);
        applyStimulus(0, OFF);
        checkOutput("enc.code_held", int'(bus.fault_code), 1);

        // Timeout fires on the MAX_DWELL-th sample, not earlier
        applyStimulus(1, OFF);
        applyStimulus(0, Y);
        applyStimulus(0, Y);
        applyStimulus(0, Y);
        checkOutput("tmo.not_yet", int'(bus.fault), 0);
        checkOutput("tmo.phase", int'(bus.phase), 2);
        applyStimulus(0, Y);
        checkOutput("tmo.fault", int'(bus.fault), 1);
        checkOutput("tmo.code", int'(bus.fault_code), 3);

        // Reset out of FAULT, then idle samples are ignored
        applyStimulus(1, Y);
        checkOutput("rst2.phase", int'(bus.phase), 0);
        checkOutput("rst2.fault", int'(bus.fault), 0);
        checkOutput("rst2.code", int'(bus.fault_code), 0);
        applyStimulus(0, OFF);
        applyStimulus(0, OFF);
        checkOutput("rst2.idle", int'(bus.phase), 0);
        applyStimulus(0, G);
        checkOutput("rst2.green", int'(bus.phase), 1);
        checkOutput("rst2.no_fault", int'(bus.fault), 0);

        // Cycle counter saturates at its maximum
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, Y);
            applyStimulus(0, R);
            applyStimulus(0, G);
        end
        checkOutput("sat.cycles", int'(bus.cycle_count), CNT_MAX);
        checkOutput("sat.done", int'(bus.phase_done), 1);

        // Illegal codes in IDLE ignored; R->Y is an order error
        applyStimulus(1, OFF);
        applyStimulus(0, 3'b111);
        applyStimulus(0, 3'b011);
        applyStimulus(0, 3'b101);
        checkOutput("idle.phase", int'(bus.phase), 0);
        checkOutput("idle.fault", int'(bus.fault), 0);
        applyStimulus(0, R);
        checkOutput("idle.enter_red", int'(bus.phase), 3);
        applyStimulus(0, Y);
        checkOutput("ry.code", int'(bus.fault_code), 2);

        #5;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
